// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-FU result slots, the register-file write port and
// the pending-destination hazard query.
interface wb_arbiter_if #(
   parameter int unsigned NREQ = 5,
   parameter int unsigned DW   = 32,
   parameter int unsigned AW   = 5
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_rd;
   logic [NREQ*DW-1:0] req_data;
   logic               wb_we;
   logic [AW-1:0]      wb_addr;
   logic [DW-1:0]      wb_data;
   logic [2:0]         wb_src;
   logic [AW-1:0]      query_addr;
   logic               query_hit;
   logic [NREQ-1:0]    slot_full;

   modport slave (
      input  req_valid, req_rd, req_data, query_addr,
      output req_ready, wb_we, wb_addr, wb_data, wb_src, query_hit, slot_full
   );

   modport master (
      output req_valid, req_rd, req_data, query_addr,
      input  req_ready, wb_we, wb_addr, wb_data, wb_src, query_hit, slot_full
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback scheduler: one holding slot per functional unit, drained round-robin
// into a single registered register-file write port.
module wb_arbiter #(
   parameter int unsigned NREQ = 5,
   parameter int unsigned DW   = 32,
   parameter int unsigned AW   = 5
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]         full_q, full_d;
   logic [NREQ-1:0][AW-1:0] rd_q, rd_d;
   logic [NREQ-1:0][DW-1:0] data_q, data_d;
   logic [RW-1:0]           rr_q, rr_d;
   logic                    wb_we_q, wb_we_d;
   logic [AW-1:0]           wb_addr_q, wb_addr_d;
   logic [DW-1:0]           wb_data_q, wb_data_d;
   logic [2:0]              wb_src_q, wb_src_d;

   logic [NREQ-1:0] grant, ready, xfer;
   logic            grant_any;
   logic [RW-1:0]   grant_idx;
   logic [RW:0]     arb_sum;
   logic [RW-1:0]   arb_idx;
   logic            hit;

   // Scan from rr upward with wrap; first full slot wins.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      arb_sum   = '0;
      arb_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         arb_sum = {1'b0, rr_q} + (RW+1)'(k);
         if (arb_sum >= (RW+1)'(NREQ)) arb_sum = arb_sum - (RW+1)'(NREQ);
         arb_idx = arb_sum[RW-1:0];
         if (!grant_any && full_q[arb_idx]) begin
            grant_any      = 1'b1;
            grant_idx      = arb_idx;
            grant[arb_idx] = 1'b1;
         end
      end
   end

   // A granted slot frees this cycle, so it may take a new result at the same edge.
   assign ready = ~full_q | grant;
   assign xfer  = bus.req_valid & ready;

   always_comb begin
      full_d = full_q;
      rd_d   = rd_q;
      data_d = data_q;
      for (int i = 0; i < NREQ; i++) begin
         if (xfer[i] && (bus.req_rd[i*AW +: AW] != '0)) begin
            full_d[i] = 1'b1;
            rd_d[i]   = bus.req_rd[i*AW +: AW];
            data_d[i] = bus.req_data[i*DW +: DW];
         end else if (grant[i]) begin
            full_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      wb_we_d   = grant_any;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      wb_src_d  = wb_src_q;
      rr_d      = rr_q;
      if (grant_any) begin
         wb_addr_d = rd_q[grant_idx];
         wb_data_d = data_q[grant_idx];
         wb_src_d  = 3'(grant_idx);
         rr_d      = (grant_idx == RW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Register x0 is never written, so it can never be a hazard.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (full_q[i] && (rd_q[i] == bus.query_addr)) hit = 1'b1;
      end
      if (wb_we_q && (wb_addr_q == bus.query_addr)) hit = 1'b1;
      if (bus.query_addr == '0) hit = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q    <= '0;
         rd_q      <= '0;
         data_q    <= '0;
         rr_q      <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_src_q  <= '0;
      end else begin
         full_q    <= full_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         rr_q      <= rr_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         wb_src_q  <= wb_src_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.wb_we     = wb_we_q;
   assign bus.wb_addr   = wb_addr_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_src    = wb_src_q;
   assign bus.query_hit = hit;
   assign bus.slot_full = full_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for the main flow plus
// hand-written sequences for hold/reload, hazard query and mid-run reset.
module tb_wb_arbiter;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   wb_arbiter_if #(.NREQ(5), .DW(32), .AW(5)) bus ();

   wb_arbiter #(.NREQ(5), .DW(32), .AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]   valid;
      logic [24:0]  rd;
      logic [159:0] data;
      logic [4:0]   qa;
      logic [4:0]   e_ready;
      logic         e_we;
      logic [4:0]   e_addr;
      logic [31:0]  e_data;
      logic [2:0]   e_src;
      logic         e_hit;
      logic [4:0]   e_full;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [4:0] valid, input logic [24:0] rd,
                              input logic [159:0] data, input logic [4:0] qa,
                              input logic [4:0] e_ready, input logic e_we,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic [2:0] e_src, input logic e_hit,
                              input logic [4:0] e_full);
      vec_t t;
      t.valid = valid;  t.rd = rd;  t.data = data;  t.qa = qa;
      t.e_ready = e_ready;  t.e_we = e_we;  t.e_addr = e_addr;  t.e_data = e_data;
      t.e_src = e_src;  t.e_hit = e_hit;  t.e_full = e_full;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] valid, input logic [24:0] rd,
                        input logic [159:0] data, input logic [4:0] qa);
      bus.req_valid  = valid;
      bus.req_rd     = rd;
      bus.req_data   = data;
      bus.query_addr = qa;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [24:0]  R0 = '0;
   localparam logic [159:0] D0 = '0;

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b0;
      drive(5'b0, R0, D0, 5'd0);

      // valid rd data qa | ready we addr data src hit full
      tbl.push_back(v(5'b00001, {20'd0, 5'd5}, {128'd0, 32'h1234}, 5'd5,
                      5'b11111, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd5,
                      5'b11111, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 5'b00001));
      tbl.push_back(v(5'b00000, R0, D0, 5'd5,
                      5'b11111, 1'b1, 5'd5, 32'h1234, 3'd0, 1'b1, 5'b00000));
      tbl.push_back(v(5'b10000, {5'd9, 20'd0}, {32'h99, 128'd0}, 5'd9,
                      5'b11111, 1'b0, 5'd5, 32'h1234, 3'd0, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd9,
                      5'b11111, 1'b0, 5'd5, 32'h1234, 3'd0, 1'b1, 5'b10000));
      tbl.push_back(v(5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
                      {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 5'd3,
                      5'b11111, 1'b1, 5'd9, 32'h99, 3'd4, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd3,
                      5'b00001, 1'b0, 5'd9, 32'h99, 3'd4, 1'b1, 5'b11111));
      tbl.push_back(v(5'b00000, R0, D0, 5'd1,
                      5'b00011, 1'b1, 5'd1, 32'hA0, 3'd0, 1'b1, 5'b11110));
      tbl.push_back(v(5'b00000, R0, D0, 5'd1,
                      5'b00111, 1'b1, 5'd2, 32'hA1, 3'd1, 1'b0, 5'b11100));
      tbl.push_back(v(5'b00000, R0, D0, 5'd0,
                      5'b01111, 1'b1, 5'd3, 32'hA2, 3'd2, 1'b0, 5'b11000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd5,
                      5'b11111, 1'b1, 5'd4, 32'hA3, 3'd3, 1'b1, 5'b10000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd5,
                      5'b11111, 1'b1, 5'd5, 32'hA4, 3'd4, 1'b1, 5'b00000));
      tbl.push_back(v(5'b00101, {10'd0, 5'd10, 5'd0, 5'd20}, {64'd0, 32'hC2, 32'd0, 32'hC0},
                      5'd0, 5'b11111, 1'b0, 5'd5, 32'hA4, 3'd4, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd20,
                      5'b11011, 1'b0, 5'd5, 32'hA4, 3'd4, 1'b1, 5'b00101));
      tbl.push_back(v(5'b01010, {5'd0, 5'd13, 5'd0, 5'd11, 5'd0},
                      {32'd0, 32'hC3, 32'd0, 32'hC1, 32'd0}, 5'd13,
                      5'b11111, 1'b1, 5'd20, 32'hC0, 3'd0, 1'b0, 5'b00100));
      tbl.push_back(v(5'b00000, R0, D0, 5'd13,
                      5'b11101, 1'b1, 5'd10, 32'hC2, 3'd2, 1'b1, 5'b01010));
      tbl.push_back(v(5'b00000, R0, D0, 5'd13,
                      5'b11111, 1'b1, 5'd13, 32'hC3, 3'd3, 1'b1, 5'b00010));
      tbl.push_back(v(5'b00000, R0, D0, 5'd11,
                      5'b11111, 1'b1, 5'd11, 32'hC1, 3'd1, 1'b1, 5'b00000));
      tbl.push_back(v(5'b10000, R0, {32'hDEAD, 128'd0}, 5'd0,
                      5'b11111, 1'b0, 5'd11, 32'hC1, 3'd1, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd0,
                      5'b11111, 1'b0, 5'd11, 32'hC1, 3'd1, 1'b0, 5'b00000));
      tbl.push_back(v(5'b00000, R0, D0, 5'd11,
                      5'b11111, 1'b0, 5'd11, 32'hC1, 3'd1, 1'b0, 5'b00000));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].valid, tbl[i].rd, tbl[i].data, tbl[i].qa);
         #1;
         chk($sformatf("v%0d.ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
         chk($sformatf("v%0d.we", i),    32'(bus.wb_we),     32'(tbl[i].e_we));
         chk($sformatf("v%0d.addr", i),  32'(bus.wb_addr),   32'(tbl[i].e_addr));
         chk($sformatf("v%0d.data", i),  bus.wb_data,        tbl[i].e_data);
         chk($sformatf("v%0d.src", i),   32'(bus.wb_src),    32'(tbl[i].e_src));
         chk($sformatf("v%0d.hit", i),   32'(bus.query_hit), 32'(tbl[i].e_hit));
         chk($sformatf("v%0d.full", i),  32'(bus.slot_full), 32'(tbl[i].e_full));
         tick();
      end

      // Fresh reset so rr=0: slot 0 wins first, slot 2 waits and back-pressures MUL.
      rst = 1'b0;
      drive(5'b0, R0, D0, 5'd0);
      #1;
      chk("rst.full", 32'(bus.slot_full), 32'h0);
      chk("rst.we", 32'(bus.wb_we), 32'h0);
      tick();
      rst = 1'b1;
      drive(5'b00101, {10'd0, 5'd2, 5'd0, 5'd1}, {64'd0, 32'h20, 32'd0, 32'h10}, 5'd0);
      #1;
      chk("mul.ready0", 32'(bus.req_ready), 32'h1f);
      tick();
      drive(5'b00100, {10'd0, 5'd3, 10'd0}, {64'd0, 32'h21, 64'd0}, 5'd0);
      #1;
      chk("mul.full1", 32'(bus.slot_full), 32'h05);
      chk("mul.ready1", 32'(bus.req_ready[2]), 32'h0);
      tick();
      #1;
      chk("mul.ready2", 32'(bus.req_ready[2]), 32'h1);
      chk("mul.we2", 32'(bus.wb_we), 32'h1);
      chk("mul.addr2", 32'(bus.wb_addr), 32'd1);
      chk("mul.data2", bus.wb_data, 32'h10);
      tick();
      drive(5'b0, R0, D0, 5'd0);
      #1;
      chk("mul.addr3", 32'(bus.wb_addr), 32'd2);
      chk("mul.data3", bus.wb_data, 32'h20);
      chk("mul.src3", 32'(bus.wb_src), 32'd2);
      chk("mul.full3", 32'(bus.slot_full), 32'h04);
      tick();
      #1;
      chk("mul.we4", 32'(bus.wb_we), 32'h1);
      chk("mul.addr4", 32'(bus.wb_addr), 32'd3);
      chk("mul.data4", bus.wb_data, 32'h21);
      chk("mul.src4", 32'(bus.wb_src), 32'd2);
      chk("mul.full4", 32'(bus.slot_full), 32'h0);
      tick();

      // DIV rd=7 hazard visible while pending and while being written.
      drive(5'b01000, {5'd0, 5'd7, 15'd0}, {32'd0, 32'h77, 96'd0}, 5'd7);
      #1;
      chk("div.hit0", 32'(bus.query_hit), 32'h0);
      tick();
      drive(5'b0, R0, D0, 5'd7);
      #1;
      chk("div.full1", 32'(bus.slot_full), 32'h08);
      chk("div.hit1", 32'(bus.query_hit), 32'h1);
      tick();
      #1;
      chk("div.we2", 32'(bus.wb_we), 32'h1);
      chk("div.addr2", 32'(bus.wb_addr), 32'd7);
      chk("div.src2", 32'(bus.wb_src), 32'd3);
      chk("div.hit2", 32'(bus.query_hit), 32'h1);
      tick();
      #1;
      chk("div.we3", 32'(bus.wb_we), 32'h0);
      chk("div.hit3", 32'(bus.query_hit), 32'h0);

      // Asynchronous reset while a write is out and slot 3 is still pending.
      drive(5'b01001, {5'd0, 5'd9, 10'd0, 5'd8}, {32'd0, 32'h90, 64'd0, 32'h80}, 5'd0);
      tick();
      drive(5'b0, R0, D0, 5'd0);
      tick();
      #1;
      chk("ar.we_pre", 32'(bus.wb_we), 32'h1);
      chk("ar.full_pre", 32'(bus.slot_full), 32'h08);
      rst = 1'b0;
      #1;
      chk("ar.full", 32'(bus.slot_full), 32'h0);
      chk("ar.we", 32'(bus.wb_we), 32'h0);
      chk("ar.addr", 32'(bus.wb_addr), 32'h0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("ar.post%0d.we", c), 32'(bus.wb_we), 32'h0);
         chk($sformatf("ar.post%0d.full", c), 32'(bus.slot_full), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
